// File: rtl/i_fetch_pkg.sv
// Shared fetch-unit constants and the {pc, word} entry layout held in the skid buffer.
package i_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 8;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 8'h00;

  // One buffered fetch: the word plus the address it came from (pc in the upper bits).
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] word;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO between the ROM read and decode. Entry 0 is always the head.
// Flush empties the buffer; a pop in the flush cycle is still a completed handshake.
module fetch_skid_buf
  import i_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  // Next-state: guard push/pop against full/empty, then shift or fill entries.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    push_ok = push & (count_q != 2'd2);
    pop_ok  = pop & (count_q != 2'd0);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = din;
          else                 ent1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        // Both only possible with exactly one entry: the new word becomes the head.
        2'b11: ent0_d = din;
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = ent0_q;

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch unit: PC register, ROM address drive, redirect handling and a
// 2-entry skid buffer feeding decode over valid/ready.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned        DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]         count;
  logic [ENTRY_W-1:0] head;
  logic               fetch_fire;
  logic               pop;

  // Fetch enable depends only on registered count, never on instr_ready.
  always_comb begin
    fetch_fire = run & ~redirect & (count != 2'd2);
    pop        = instr_valid & instr_ready;
    pc_d       = pc_q;
    if (redirect)        pc_d = redirect_pc;
    else if (fetch_fire) pc_d = pc_q + 1'b1;
  end

  // PC register; reset beats redirect.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_skid_buf #(
    .WIDTH (ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_fire),
    .pop   (pop),
    .flush (redirect),
    .din   ({pc_q, imem_data}),
    .count (count),
    .head  (head)
  );

  assign imem_addr   = pc_q;
  assign instr       = head[DATA_W-1:0];
  assign instr_pc    = head[ENTRY_W-1:DATA_W];
  assign instr_valid = (count != 2'd0);

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch with a small combinational instruction ROM model.
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Team ROM: known words at the addresses the directed steps rely on, a tagged pattern elsewhere.
  function automatic logic [31:0] rom(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h0036E401;
      8'd1:    return 32'h0036E018;
      8'd2:    return 32'h0010E0FF;
      8'd14:   return 32'h0336E700;
      default: return {8'hC0, a, 8'h3C, a};
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  i_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Head entry must be valid and carry the ROM word for pc.
  task automatic chk_head(input string tag, input logic [7:0] pc);
    chk({tag, ".valid"}, 64'(instr_valid), 64'(1'b1));
    chk({tag, ".pc"}, 64'(instr_pc), 64'(pc));
    chk({tag, ".instr"}, 64'(instr), 64'(rom(pc)));
  endtask

  task automatic do_reset(input logic r_run, input logic r_ready);
    rst = 1'b1; run = r_run; instr_ready = r_ready; redirect = 1'b0; redirect_pc = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset state, then one instruction per cycle
    do_reset(1'b1, 1'b1);
    chk("rst.valid", 64'(instr_valid), 64'(1'b0));
    chk("rst.instr", 64'(instr), 64'h0);
    chk("rst.pc", 64'(instr_pc), 64'h0);
    chk("rst.addr", 64'(imem_addr), 64'h0);
    tick(); chk("t1.i0", 64'(instr), 64'h0036E401); chk_head("t1.h0", 8'd0);
    tick(); chk("t1.i1", 64'(instr), 64'h0036E018); chk_head("t1.h1", 8'd1);
    tick(); chk("t1.i2", 64'(instr), 64'h0010E0FF); chk_head("t1.h2", 8'd2);
    tick(); chk_head("t1.h3", 8'd3);

    // 2: backpressure fills the buffer and stalls the PC, then drain in order
    do_reset(1'b1, 1'b0);
    tick(); tick();
    chk("t2.addr", 64'(imem_addr), 64'd2);
    chk_head("t2.hold0", 8'd0);
    tick();
    chk("t2.stall", 64'(imem_addr), 64'd2);
    chk_head("t2.hold1", 8'd0);
    instr_ready = 1'b1;
    tick(); chk_head("t2.d1", 8'd1);
    tick(); chk_head("t2.d2", 8'd2);
    tick(); chk_head("t2.d3", 8'd3);

    // 3: redirect with two words buffered and ready low
    do_reset(1'b1, 1'b0);
    tick(); tick();
    redirect = 1'b1; redirect_pc = 8'd14;
    tick();
    redirect = 1'b0;
    chk("t3.flush", 64'(instr_valid), 64'(1'b0));
    chk("t3.addr", 64'(imem_addr), 64'd14);
    tick();
    chk("t3.word", 64'(instr), 64'h0336E700);
    chk_head("t3.h", 8'd14);

    // 4: redirect coinciding with a pop of pc 14; pc 15 must never surface
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'd40;
    tick();
    redirect = 1'b0;
    chk("t4.flush", 64'(instr_valid), 64'(1'b0));
    chk("t4.addr", 64'(imem_addr), 64'd40);
    tick(); chk_head("t4.h40", 8'd40);
    tick(); chk_head("t4.h41", 8'd41);

    // 5: PC wrap through 8'hFF
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    chk("t5.addr", 64'(imem_addr), 64'hFF);
    tick(); chk_head("t5.hFF", 8'hFF);
    tick(); chk_head("t5.h00", 8'h00);
    tick(); chk_head("t5.h01", 8'h01);

    // 6a: run=0 with two buffered, partial drain, then reset mid-drain
    do_reset(1'b1, 1'b0);
    tick(); tick();
    run = 1'b0;
    tick();
    chk("t6.frozen", 64'(imem_addr), 64'd2);
    chk_head("t6.hold", 8'd0);
    instr_ready = 1'b1;
    tick(); chk_head("t6.d1", 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6.rvalid", 64'(instr_valid), 64'(1'b0));
    chk("t6.raddr", 64'(imem_addr), 64'(8'h00));
    tick();
    chk("t6.idle", 64'(instr_valid), 64'(1'b0));

    // 6b: run=0 alone drains two words, then empty with PC frozen
    do_reset(1'b1, 1'b0);
    tick(); tick();
    run = 1'b0; instr_ready = 1'b1;
    tick(); chk_head("t6b.d1", 8'd1);
    tick();
    chk("t6b.empty", 64'(instr_valid), 64'(1'b0));
    chk("t6b.pc", 64'(imem_addr), 64'd2);
    tick();
    chk("t6b.pc2", 64'(imem_addr), 64'd2);

    // Redirect while run=0: PC moves, nothing fetched until run returns
    redirect = 1'b1; redirect_pc = 8'd50;
    tick();
    redirect = 1'b0;
    chk("rd0.addr", 64'(imem_addr), 64'd50);
    tick();
    chk("rd0.valid", 64'(instr_valid), 64'(1'b0));
    run = 1'b1;
    tick(); chk_head("rd0.h50", 8'd50);

    // Reset overrides a simultaneous redirect
    rst = 1'b1; redirect = 1'b1; redirect_pc = 8'd99;
    tick();
    rst = 1'b0; redirect = 1'b0;
    chk("rstpri.addr", 64'(imem_addr), 64'(8'h00));
    chk("rstpri.valid", 64'(instr_valid), 64'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
